seg_frame_arbiter: RTL and testbench
====================================

// Module: seg_frame_arbiter
// PURPOSE
//  Owns the 8-digit display frame buffer feeding seg_controller's seg_0..seg_7 inputs.
//  Arbitrates digit writes between two requesters (A = keypad, B = slot game) with round-robin.
//  Decodes each stored hex/blank code to 7-segment patterns and applies a per-digit blink.
//  Sits between the application logic and the scanner.
// PARAMETERS
//  BLINK_DIV  default 25_000_000  clk cycles per blink half-period (>=2)
// PORTS
//  clk       in   1   system clock
//  rst_x     in   1   reset; asynchronous, active-low
//  clr       in   1   sync clear: all digits blank, blink off
//  a_req     in   1   requester A write request; hold until a_gnt
//  a_idx     in   3   A target digit 0..7
//  a_val     in   5   A code: bit4=1 blank, else [3:0] hex digit
//  a_blink   in   1   A blink enable for the target digit
//  a_gnt     out  1   A write accepted this cycle (combinational)
//  b_req     in   1   requester B write request; hold until b_gnt
//  b_idx     in   3   B target digit
//  b_val     in   5   B code, same encoding as a_val
//  b_blink   in   1   B blink enable
//  b_gnt     out  1   B write accepted this cycle (combinational)
//  seg_0..seg_7 out 7 each  registered segment pattern, bit0=a..bit6=g, 1=lit
// BEHAVIOUR
//  Reset: buffer all {val=5'h10, blink=0}; seg_0..7=7'h00; blink counter=0; phase=0; last_gnt=B.
//  Grant: a_gnt/b_gnt are combinational, at most one high per cycle.
//   - clr=1: both gnt=0.
//   - only one req: that requester is granted.
//   - both req: grant goes to the requester NOT in last_gnt. After reset, A wins first.
//   - last_gnt updates at any edge with a grant; it holds otherwise.
//  Write: at the edge where gnt=1, buffer[idx] <= {val, blink}. Other entries hold.
//  clr: at the edge, all entries become blank with blink=0. clr overrides any pending request.
//  Blink: counter runs 0..BLINK_DIV-1 and wraps; phase toggles on the wrap. It runs continuously and is unaffected by clr.
//  Output: every edge, seg_N <= (buf[N].blink & phase) ? 7'h00 : dec(buf[N].val).
//   - A write accepted at edge k is visible on seg_N after edge k+1 (2-cycle latency from req).
//  dec: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71;
//   bit4=1 -> 00 regardless of [3:0].
//  Back-to-back: a requester holding req after its grant is granted again only if the other is idle. Rotation guarantees it is served within 2 cycles.
//  Same idx from A and B on consecutive grants: the later write wins.
//  rst_x low mid-operation: immediate return to reset state, gnt forced 0; any pending req is re-arbitrated after release.
// TESTING
//  1 reset, no reqs -> all seg=00, gnt=0 for 20 cycles.
//  2 a_req idx=3 val=5 blink=0 -> a_gnt same cycle; seg_3=6D two edges after req; others 00.
//  3 a_req and b_req held together, 4 writes each -> gnt sequence A,B,A,B... starting A; no cycle with both gnt.
//  4 BLINK_DIV=4, digit 0 val=8 blink=1 -> seg_0 alternates 7F/00 every 4 cycles; digit 1 unblinked stays steady.
//  5 clr asserted while b_req pending -> b_gnt=0 that cycle; all seg=00 next edge+1; B granted after clr drops.
//  6 rst_x pulsed mid-stream with val=5'h1F and hex writes -> seg all 00, last_gnt=B, the first grant after release goes to A; bit4 code stays blank.

Source files
------------

// File: rtl/seg_frame_arbiter.sv
// seg_frame_arbiter: 8-digit display frame buffer with round-robin write
// arbitration between two requesters, hex decode and per-digit blink.
module seg_frame_arbiter #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       clr,
    input  logic       a_req,
    input  logic [2:0] a_idx,
    input  logic [4:0] a_val,
    input  logic       a_blink,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [2:0] b_idx,
    input  logic [4:0] b_val,
    input  logic       b_blink,
    output logic       b_gnt,
    output logic [6:0] seg_0,
    output logic [6:0] seg_1,
    output logic [6:0] seg_2,
    output logic [6:0] seg_3,
    output logic [6:0] seg_4,
    output logic [6:0] seg_5,
    output logic [6:0] seg_6,
    output logic [6:0] seg_7
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [4:0]    val_q [8];
    logic [7:0]    blink_q;
    logic [6:0]    seg_q [8];
    logic          last_b;
    logic [CW-1:0] cnt;
    logic          phase;

    logic          wr_en;
    logic [2:0]    wr_idx;
    logic [4:0]    wr_val;
    logic          wr_blink;

    function automatic logic [6:0] dec(input logic [4:0] v);
        logic [6:0] p;
        if (v[4]) begin
            p = 7'h00;
        end else begin
            case (v[3:0])
                4'h0: p = 7'h3F;
                4'h1: p = 7'h06;
                4'h2: p = 7'h5B;
                4'h3: p = 7'h4F;
                4'h4: p = 7'h66;
                4'h5: p = 7'h6D;
                4'h6: p = 7'h7D;
                4'h7: p = 7'h07;
                4'h8: p = 7'h7F;
                4'h9: p = 7'h6F;
                4'hA: p = 7'h77;
                4'hB: p = 7'h7C;
                4'hC: p = 7'h39;
                4'hD: p = 7'h5E;
                4'hE: p = 7'h79;
                default: p = 7'h71;
            endcase
        end
        return p;
    endfunction

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        a_gnt = rst_x & ~clr & a_req & (~b_req | last_b);
        b_gnt = rst_x & ~clr & b_req & (~a_req | ~last_b);
    end

    // Select the winning requester's write payload.
    always_comb begin
        wr_en    = a_gnt | b_gnt;
        wr_idx   = a_gnt ? a_idx   : b_idx;
        wr_val   = a_gnt ? a_val   : b_val;
        wr_blink = a_gnt ? a_blink : b_blink;
    end

    // Remember who was served last; reset favours A on first contention.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            last_b <= 1'b1;
        end else if (wr_en) begin
            last_b <= b_gnt;
        end
    end

    // Frame buffer: clear blanks everything, else apply the granted write.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int i = 0; i < 8; i++) begin
                val_q[i] <= 5'h10;
            end
            blink_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < 8; i++) begin
                val_q[i] <= 5'h10;
            end
            blink_q <= '0;
        end else if (wr_en) begin
            val_q[wr_idx]   <= wr_val;
            blink_q[wr_idx] <= wr_blink;
        end
    end

    // Free-running blink timebase; phase flips on every counter wrap.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered segment patterns, blanked during the blink-off phase.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int i = 0; i < 8; i++) begin
                seg_q[i] <= 7'h00;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                seg_q[i] <= (blink_q[i] & phase) ? 7'h00 : dec(val_q[i]);
            end
        end
    end

    assign seg_0 = seg_q[0];
    assign seg_1 = seg_q[1];
    assign seg_2 = seg_q[2];
    assign seg_3 = seg_q[3];
    assign seg_4 = seg_q[4];
    assign seg_5 = seg_q[5];
    assign seg_6 = seg_q[6];
    assign seg_7 = seg_q[7];

endmodule

// File: tb/tb_seg_frame_arbiter.sv
// tb_seg_frame_arbiter: directed stimulus with a queue-based scoreboard
// for grants and segment outputs of seg_frame_arbiter.
module tb_seg_frame_arbiter;

    localparam int BD = 4;

    typedef struct {
        int         due;
        int         idx;
        logic [6:0] exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst_x = 1'b0;
    logic       clr = 1'b0;
    logic       a_req = 1'b0;
    logic [2:0] a_idx = '0;
    logic [4:0] a_val = '0;
    logic       a_blink = 1'b0;
    logic       a_gnt;
    logic       b_req = 1'b0;
    logic [2:0] b_idx = '0;
    logic [4:0] b_val = '0;
    logic       b_blink = 1'b0;
    logic       b_gnt;
    logic [6:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic [6:0] segv [8];

    assign segv[0] = s0;
    assign segv[1] = s1;
    assign segv[2] = s2;
    assign segv[3] = s3;
    assign segv[4] = s4;
    assign segv[5] = s5;
    assign segv[6] = s6;
    assign segv[7] = s7;

    seg_frame_arbiter #(.BLINK_DIV(BD)) dut (
        .clk(clk), .rst_x(rst_x), .clr(clr),
        .a_req(a_req), .a_idx(a_idx), .a_val(a_val),
        .a_blink(a_blink), .a_gnt(a_gnt),
        .b_req(b_req), .b_idx(b_idx), .b_val(b_val),
        .b_blink(b_blink), .b_gnt(b_gnt),
        .seg_0(s0), .seg_1(s1), .seg_2(s2), .seg_3(s3),
        .seg_4(s4), .seg_5(s5), .seg_6(s6), .seg_7(s7)
    );

    always #5 clk = ~clk;

    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   gnt_q [$];
    chk_t seg_q [$];

    logic [6:0] t3_exp [8];

    // edges since the last reset release
    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // scoreboard monitor
    always @(negedge clk) begin : mon
        chk_t c;
        bit   e;
        if (!rst_x) begin
            n_cmp++;
            if (a_gnt || b_gnt) begin
                n_bad++;
                $display("FAIL gnt_in_reset: a_gnt=%b b_gnt=%b required 0 0",
                         a_gnt, b_gnt);
            end
        end else begin
            if (a_gnt && b_gnt) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_gnt: cyc=%0d a_gnt=1 b_gnt=1 required one", cyc);
            end else if (a_gnt || b_gnt) begin
                n_cmp++;
                if (gnt_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_gnt: cyc=%0d a=%b b=%b required none",
                             cyc, a_gnt, b_gnt);
                end else begin
                    e = gnt_q.pop_front();
                    if (b_gnt != e) begin
                        n_bad++;
                        $display("FAIL gnt_order: cyc=%0d got %s required %s",
                                 cyc, b_gnt ? "B" : "A", e ? "B" : "A");
                    end
                end
            end
            while (seg_q.size() > 0 && seg_q[0].due <= cyc) begin
                c = seg_q.pop_front();
                n_cmp++;
                if (segv[c.idx] !== c.exp) begin
                    n_bad++;
                    $display("FAIL seg_%0d: cyc=%0d got %h required %h",
                             c.idx, cyc, segv[c.idx], c.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seg(input int due, input int idx, input logic [6:0] exp);
        chk_t c;
        c.due = due;
        c.idx = idx;
        c.exp = exp;
        seg_q.push_back(c);
    endtask

    // single write; g = cyc at the negedge where the grant was seen
    task automatic wr(input bit who, input int idx, input logic [4:0] val,
                      input bit bl, output int g);
        gnt_q.push_back(who);
        if (!who) begin
            a_req = 1'b1; a_idx = 3'(idx); a_val = val; a_blink = bl;
        end else begin
            b_req = 1'b1; b_idx = 3'(idx); b_val = val; b_blink = bl;
        end
        g = -1;
        for (int k = 0; k < 8 && g < 0; k++) begin
            @(negedge clk);
            if (who ? b_gnt : a_gnt) g = cyc;
        end
        if (g < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_timeout: req %s got no gnt required gnt",
                     who ? "B" : "A");
            void'(gnt_q.pop_back());
        end
        tick();
        if (!who) a_req = 1'b0;
        else      b_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired required finish");
        $fatal(1);
    end

    initial begin : stim
        int g, g2, c0, last, ca, cb;
        bit ga, gb;

        t3_exp = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E};

        repeat (3) tick();
        rst_x = 1'b1;

        // 1: idle after reset
        for (int m = 1; m <= 20; m++)
            for (int i = 0; i < 8; i++) push_seg(m, i, 7'h00);
        repeat (21) tick();

        // 2: single A write, two-edge latency
        wr(1'b0, 3, 5'h05, 1'b0, g);
        for (int i = 0; i < 8; i++)
            push_seg(g + 2, i, (i == 3) ? 7'h6D : 7'h00);
        repeat (3) tick();

        // 3: contention, strict alternation starting with A
        wr(1'b1, 7, 5'h0E, 1'b0, g);
        tick();
        for (int k = 0; k < 4; k++) begin
            gnt_q.push_back(1'b0);
            gnt_q.push_back(1'b1);
        end
        ca = 0; cb = 0; last = -1;
        a_req = 1'b1; a_idx = 3'd0; a_val = 5'd1;
        b_req = 1'b1; b_idx = 3'd4; b_val = 5'd10;
        for (int k = 0; k < 40 && (ca < 4 || cb < 4); k++) begin
            @(negedge clk);
            ga = a_gnt;
            gb = b_gnt;
            if (ga || gb) last = cyc;
            tick();
            if (ga) begin
                ca++;
                if (ca == 4) a_req = 1'b0;
                else begin a_idx = 3'(ca); a_val = 5'(ca + 1); end
            end
            if (gb) begin
                cb++;
                if (cb == 4) b_req = 1'b0;
                else begin b_idx = 3'(4 + cb); b_val = 5'(10 + cb); end
            end
        end
        if (ca < 4 || cb < 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rr_timeout: a=%0d b=%0d grants required 4 4", ca, cb);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 8; i++) push_seg(last + 2, i, t3_exp[i]);
        repeat (3) tick();

        // 4: blink on digit 0, steady digit 1
        wr(1'b0, 0, 5'h08, 1'b1, g);
        wr(1'b1, 1, 5'h09, 1'b0, g2);
        for (int m = g2 + 2; m < g2 + 18; m++) begin
            push_seg(m, 0, (((m - 1) / BD) % 2 == 1) ? 7'h00 : 7'h7F);
            push_seg(m, 1, 7'h6F);
        end
        repeat (19) tick();

        // 5: clear while B is requesting
        clr = 1'b1;
        b_req = 1'b1; b_idx = 3'd2; b_val = 5'h07; b_blink = 1'b0;
        @(negedge clk);
        c0 = cyc;
        n_cmp++;
        if (b_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_gnt: b_gnt=%b required 0", b_gnt);
        end
        for (int i = 0; i < 8; i++) push_seg(c0 + 2, i, 7'h00);
        tick();
        clr = 1'b0;
        gnt_q.push_back(1'b1);
        g = -1;
        for (int k = 0; k < 8 && g < 0; k++) begin
            @(negedge clk);
            if (b_gnt) g = cyc;
        end
        if (g < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL clr_release: b_gnt never seen required 1");
            void'(gnt_q.pop_back());
        end
        tick();
        b_req = 1'b0;
        for (int i = 0; i < 8; i++)
            push_seg(g + 2, i, (i == 2) ? 7'h07 : 7'h00);
        repeat (4) tick();

        // 6: blank code, then reset mid-stream with both requesting
        wr(1'b1, 5, 5'h03, 1'b0, g);
        wr(1'b0, 4, 5'h1F, 1'b0, g);
        push_seg(g + 2, 4, 7'h00);
        push_seg(g + 2, 5, 7'h4F);
        repeat (3) tick();
        a_req = 1'b1; a_idx = 3'd6; a_val = 5'h05;
        b_req = 1'b1; b_idx = 3'd6; b_val = 5'h0C;
        #2;
        rst_x = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (segv[i] !== 7'h00) begin
                n_bad++;
                $display("FAIL rst_seg_%0d: got %h required 00", i, segv[i]);
            end
        end
        tick();
        tick();
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        rst_x = 1'b1;
        ca = 0; cb = 0;
        for (int k = 0; k < 10 && (ca < 1 || cb < 1); k++) begin
            @(negedge clk);
            ga = a_gnt;
            gb = b_gnt;
            if (ga) begin
                for (int i = 0; i < 8; i++)
                    push_seg(cyc + 2, i, (i == 6) ? 7'h6D : 7'h00);
            end
            if (gb) begin
                for (int i = 0; i < 8; i++)
                    push_seg(cyc + 2, i, (i == 6) ? 7'h39 : 7'h00);
            end
            tick();
            if (ga) begin ca++; a_req = 1'b0; end
            if (gb) begin cb++; b_req = 1'b0; end
        end
        if (ca < 1 || cb < 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL post_rst_timeout: a=%0d b=%0d grants required 1 1", ca, cb);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (5) tick();

        n_cmp++;
        if (gnt_q.size() != 0 || seg_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: gnt_q=%0d seg_q=%0d left required 0 0",
                     gnt_q.size(), seg_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
